mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - Unified instruction/data memory plus IR and MDR for the multicycle MIPS datapath.
// - Sits directly downstream of the control FSM.
// - Consumes MemRead/MemWrite/IRWrite and the IorD-selected address; models a memory with configurable wait states.
// - Reports completion so the FSM can stall.
// PARAMETERS
// - DATA_W   32   data/instruction word width
// - ADDR_W   32   byte-address width
// - DEPTH    256  number of words; power of two; index = addr[log2(DEPTH)+1:2]
// - LATENCY  2    wait cycles between accept and access; 0..15
// PORTS
// - clk          in   1       single clock, rising edge
// - rst          in   1       synchronous, active-high reset
// - mem_read     in   1       read request (control MemRead)
// - mem_write    in   1       write request (control MemWrite)
// - ir_write     in   1       on read completion, also load IR (control IRWrite)
// - addr         in   ADDR_W  byte address (already muxed by IorD)
// - wdata        in   DATA_W  store data (register B)
// - instr        out  DATA_W  instruction register; opcode = instr[31:26]
// - mdr          out  DATA_W  memory data register
// - busy         out  1       request accepted and not yet complete
// - done         out  1       one-cycle pulse in the access cycle
// - align_err    out  1       only when MEM_ALIGN_CHECK_EN is defined
// BEHAVIOUR
// - Reset values: instr=0, mdr=0, busy=0, done=0, align_err=0, state=IDLE.
// - Memory array contents are not cleared by rst.
// - FSM has three states:
//   - IDLE: if mem_read|mem_write, latch addr, wdata, op and ir_write. Set busy=1 next cycle.
//     - If LATENCY=0, go to ACCESS; else go to WAIT with cnt=LATENCY-1.
//   - WAIT: if cnt==0, go to ACCESS; else decrement cnt.
//   - ACCESS: perform the operation, pulse done=1, set busy=0 next cycle, return to IDLE.
// - Latency: done is asserted exactly LATENCY+1 cycles after the accept edge.
//   - A new request can be accepted in the cycle after done.
// - Read, in ACCESS: mdr <= mem[idx]. If the latched ir_write=1, also instr <= mem[idx].
//   - The new values are visible the cycle after done. They hold until the next read.
// - Write, in ACCESS: mem[idx] <= latched wdata. mdr and instr are unchanged.
// - mem_read and mem_write both high at accept: treated as a write; the read is dropped.
// - Requests while busy=1 are ignored; they are not queued.
// - Inputs change freely after accept; only latched values are used.
// - Address above DEPTH*4: wraps, since only the index bits are used. addr[1:0] is ignored.
// - ir_write without mem_read at accept has no effect.
// - rst during WAIT or ACCESS aborts the request:
//   - No memory write, done is not pulsed.
//   - Outputs return to reset values on the next edge.
// - Combinational read of mem, 32-bit word-aligned storage; no byte enables.
// CONFIGURATION
// - MEM_ALIGN_CHECK_EN defined:
//   - align_err port exists.
//   - Request with addr[1:0]!=0 still completes with done.
//   - A misaligned write is suppressed (mem unchanged).
//   - A misaligned read leaves mdr and instr unchanged.
//   - align_err=1 in the done cycle only.
// - MEM_ALIGN_CHECK_EN undefined: no align_err port; addr[1:0] is silently ignored.
// TESTING
// - Write then read back, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF. done 3 cycles after accept.
//   - Then read 0x10 with ir_write=0: mdr=0xDEADBEEF, instr unchanged.
// - Fetch: mem[0]=0x8C220004, read addr=0 with ir_write=1 -> instr=mdr=0x8C220004, instr[31:26]=6'b100011.
// - Busy ignore: during WAIT, pulse mem_write to addr 0x20 with 0x1234 -> mem[8] unchanged.
//   - Exactly one done pulse.
// - Simultaneous read+write: addr=0x4, wdata=0x55AA55AA -> mem[1]=0x55AA55AA, mdr unchanged.
// - Reset mid-op: write 0xFFFF0000 to 0x8, assert rst in WAIT -> busy=0, no done, mem[2] unchanged.
// - With MEM_ALIGN_CHECK_EN: write addr=0x12 -> align_err=1 with done, mem[4] unchanged.
//   - Without the macro, the same write lands in mem[4].
// - LATENCY=0 build: done is asserted the cycle after accept.
// - Wrap: with DEPTH=256, write addr=0x400 -> mem[0] updated.

Source files
------------

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Unified instruction/data memory with instruction register (IR) and memory
// data register (MDR) for a multicycle MIPS datapath. A request from the
// control FSM is latched in IDLE. The unit then waits LATENCY cycles and
// performs the access in a single ACCESS cycle. done pulses in that cycle so
// the control FSM can stall until the access completes.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When defined, the align_err port exists. A request whose addr[1:0] != 0
//   still completes with done, but the access is suppressed: a misaligned
//   write leaves memory unchanged, and a misaligned read leaves mdr and instr
//   unchanged. align_err is high in the done cycle only.
//   When undefined, addr[1:0] is ignored.
//
// Parameters
//   DATA_W   data/instruction word width
//   ADDR_W   byte-address width
//   DEPTH    number of words; must be a power of two
//   LATENCY  wait cycles between accept and access (0..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   mem_read   in   read request
//   mem_write  in   write request; wins over mem_read when both are high
//   ir_write   in   on read completion, also load instr
//   addr       in   byte address; word index = addr[log2(DEPTH)+1:2]
//   wdata      in   store data
//   instr      out  instruction register
//   mdr        out  memory data register
//   busy       out  request accepted and not yet complete
//   done       out  one-cycle pulse in the access cycle
//   align_err  out  misaligned request flag (MEM_ALIGN_CHECK_EN only)
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess
    } state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                is_write_q;
    logic                irw_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata;
    logic                access_ok;
    logic                mem_we;

    // Address bits outside the word index do not affect storage: upper bits
    // wrap, and the byte offset only matters for the alignment check.
`ifdef MEM_ALIGN_CHECK_EN
    logic                misaligned_q;
    logic                unused_addr;
    assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];
    assign access_ok   = ~misaligned_q;
`else
    logic                unused_addr;
    assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};
    assign access_ok   = 1'b1;
`endif

    // Combinational read of the latched word.
    assign rdata = mem[idx_q];

    // Writes happen only on the edge that ends ACCESS. rst on that edge
    // aborts the request, so the store is suppressed as well.
    assign mem_we = (state_q == StAccess) && !rst && is_write_q && access_ok;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Control FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            irw_q      <= 1'b0;
            instr      <= '0;
            mdr        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
            align_err    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        idx_q      <= addr[IDX_W+1:2];
                        wdata_q    <= wdata;
                        // A write wins when both requests are high.
                        is_write_q <= mem_write;
                        irw_q      <= ir_write;
                        busy       <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                        misaligned_q <= |addr[1:0];
`endif
                        if (LATENCY == 0) begin
                            state_q <= StAccess;
                            done    <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                            align_err <= |addr[1:0];
`endif
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end

                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StAccess;
                        done    <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                        align_err <= misaligned_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StAccess: begin
                    // irw_q only matters for reads; it is ignored for writes.
                    if (!is_write_q && access_ok) begin
                        mdr <= rdata;
                        if (irw_q) begin
                            instr <= rdata;
                        end
                    end
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
`ifdef MEM_ALIGN_CHECK_EN
                    align_err <= 1'b0;
`endif
                end

                default: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
